// File: rtl/week6_debounce_edge_counter_pkg.sv
// Shared definitions for the week 6 debounce / edge-counter block.
//   state_t           : debounce FSM states (2-bit encodings fixed for
//                       compatibility with the course's older header)
//   DEF_STABLE_CYCLES : default number of agreeing samples before the
//                       debounced level changes
//   DEF_CNT_W         : default press-counter width
package week6_debounce_edge_counter_pkg;

  localparam int DEF_STABLE_CYCLES = 4;
  localparam int DEF_CNT_W         = 4;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_HELD         = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/week6_debounce_edge_counter_sync2.sv
// week6_sync2: two-flop synchroniser for a single asynchronous input.
//   RESET_VAL : value both flops take while rst_n is low
//   clk       : destination clock
//   rst_n     : asynchronous active-low reset
//   d         : asynchronous input
//   q         : synchronised output (two clk edges of latency)
module week6_sync2
  import week6_debounce_edge_counter_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/week6_debounce_edge_counter.sv
// week6_debounce_edge_counter: synchronises and debounces an active-low
// push button, producing a clean pressed level, one-cycle press/release
// pulses and a running press count.
//   STABLE_CYCLES : agreeing samples needed to change state (2..65535)
//   CNT_W         : press counter width
//   clk           : rising-edge clock
//   rst_n         : asynchronous active-low reset
//   btn_n         : raw button, 0 = pressed, asynchronous, may bounce
//   pressed       : debounced level, 1 = pressed (registered)
//   press_pulse   : one-cycle pulse on each debounced press
//   release_pulse : one-cycle pulse on each debounced release
//   press_count   : debounced presses since reset
// Build option: define DEBOUNCE_CNT_SAT_EN to make press_count saturate at
// all-ones instead of wrapping to zero.
module week6_debounce_edge_counter
  import week6_debounce_edge_counter_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_n,
  output logic             pressed,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic [CNT_W-1:0] press_count
);

  localparam int              SC_W    = $clog2(STABLE_CYCLES) + 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STABLE_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);

  logic            s2;
  logic            raw;
  logic            press_fire;
  state_t          state;
  logic [SC_W-1:0] stab_cnt;

  // Flops reset to 1 so a button held through reset looks released and
  // must fully requalify afterwards.
  week6_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_n),
    .q    (s2)
  );

  assign raw = ~s2;

  // Same condition that moves WAIT_PRESS -> HELD; lets the counter step on
  // the edge that registers press_pulse.
  assign press_fire = (state == ST_WAIT_PRESS) && raw && (stab_cnt == SC_LAST);

  // The entry transition already counts as the first agreeing sample, so
  // the counter starts at 1 and qualification ends at STABLE_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      stab_cnt      <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (raw) begin
            state    <= ST_WAIT_PRESS;
            stab_cnt <= SC_ONE;
          end
        end
        ST_WAIT_PRESS: begin
          if (!raw) begin
            state    <= ST_IDLE;
            stab_cnt <= '0;
          end else if (stab_cnt == SC_LAST) begin
            state       <= ST_HELD;
            stab_cnt    <= '0;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + SC_ONE;
          end
        end
        ST_HELD: begin
          if (!raw) begin
            state    <= ST_WAIT_RELEASE;
            stab_cnt <= SC_ONE;
          end
        end
        ST_WAIT_RELEASE: begin
          if (raw) begin
            state    <= ST_HELD;
            stab_cnt <= '0;
          end else if (stab_cnt == SC_LAST) begin
            state         <= ST_IDLE;
            stab_cnt      <= '0;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + SC_ONE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          stab_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_count <= '0;
    end else if (press_fire) begin
`ifdef DEBOUNCE_CNT_SAT_EN
      if (press_count != '1) begin
        press_count <= press_count + 1'b1;
      end
`else
      press_count <= press_count + 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_week6_debounce_edge_counter.sv
// Scoreboard bench for week6_debounce_edge_counter (STABLE_CYCLES=4,
// CNT_W=4, 10 ns clock). The stimulus pushes each expected pulse with its
// hand-computed cycle and count; the monitor checks every cycle at the
// falling edge and pops events as their cycle arrives.
module tb_week6_debounce_edge_counter;

  localparam int SC  = 4;
  localparam int CW  = 4;
  localparam int LAT = SC + 2;   // edges from input change to pulse
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          btn_n = 1'b0;
  logic          pressed;
  logic          press_pulse;
  logic          release_pulse;
  logic [CW-1:0] press_count;

  week6_debounce_edge_counter #(
    .STABLE_CYCLES(SC),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_n        (btn_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  always #5 clk = ~clk;

  typedef enum {EV_PRESS, EV_RELEASE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       count;
  } ev_t;

  ev_t sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int   stim_count = 0;
  logic exp_pressed = 1'b0;
  int   exp_count   = 0;
  logic exp_pp;
  logic exp_rp;
  ev_t  ev;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    exp_pp = 1'b0;
    exp_rp = 1'b0;
    if (!rst_n) begin
      exp_pressed = 1'b0;
      exp_count   = 0;
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        ev = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missed_event at cycle %0d: got nothing, expected %s at cycle %0d",
                 cyc, (ev.kind == EV_PRESS) ? "press" : "release", ev.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front();
        exp_count = ev.count;
        if (ev.kind == EV_PRESS) begin
          exp_pp      = 1'b1;
          exp_pressed = 1'b1;
        end else begin
          exp_rp      = 1'b1;
          exp_pressed = 1'b0;
        end
      end
    end
    chk("pressed",       int'(pressed),       int'(exp_pressed));
    chk("press_pulse",   int'(press_pulse),   int'(exp_pp));
    chk("release_pulse", int'(release_pulse), int'(exp_rp));
    chk("press_count",   int'(press_count),   exp_count);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int next_count(input int c);
`ifdef DEBOUNCE_CNT_SAT_EN
    return (c == CNT_MAX) ? CNT_MAX : c + 1;
`else
    return (c + 1) & CNT_MAX;
`endif
  endfunction

  task automatic push(input ev_kind_t k, input int c);
    ev_t e;
    e.kind  = k;
    e.cyc   = cyc + LAT;
    e.count = c;
    sb.push_back(e);
  endtask

  task automatic press(input int hold);
    btn_n      = 1'b0;
    stim_count = next_count(stim_count);
    push(EV_PRESS, stim_count);
    repeat (hold) tick();
  endtask

  task automatic let_go(input int hold);
    btn_n = 1'b1;
    push(EV_RELEASE, stim_count);
    repeat (hold) tick();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sb.delete();
    stim_count = 0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with the button pressed: outputs stay 0, then a full
    // qualification after deassertion.
    repeat (3) tick();
    rst_n      = 1'b1;
    stim_count = next_count(stim_count);
    push(EV_PRESS, stim_count);
    repeat (12) tick();
    let_go(12);

    // Clean press and release.
    press(20);
    let_go(20);

    // Bounce: 3-cycle runs never qualify.
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0;
      repeat (3) tick();
      btn_n = 1'b1;
      repeat (3) tick();
    end
    repeat (12) tick();

    // Counter wrap (or saturation) over 17 presses from zero.
    do_reset(2);
    repeat (4) tick();
    for (int i = 1; i <= 17; i++) begin
      press(8);
      let_go(8);
    end

    // Reset during WAIT_PRESS with the button still held.
    btn_n = 1'b0;
    repeat (4) tick();
    do_reset(3);
    stim_count = next_count(stim_count);
    push(EV_PRESS, stim_count);
    repeat (12) tick();
    let_go(12);
    repeat (4) tick();

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected end of stimulus", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
